percep_infer_ctrl: RTL and testbench

Sequencing controller for the perceptron inference datapath. After infer_ena it runs two phases:
- Load: streams the 100 inference words into the ydx memory, then the 5 weights into the weight register file.
- Run: walks the 20 samples, issuing 5 operand reads per sample to the fp16 MAC/activation datapath, comparing each returned ya with the stored yd, and counting matches.
It sits between percep_top's stimulus inputs (infer_ena, d_txt_in) and the memory/datapath, and produces infer_done and infer_fail.

---
 rtl/percep_infer_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_percep_infer_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/percep_infer_ctrl.sv
// Perceptron inference sequencer: loads the ydx memory and weights, then issues MAC operands and scores each ya against yd.
// Optional watchdog on the result wait is enabled with `define PERCEP_CTRL_TIMEOUT_EN (adds timeout_err_o).
module percep_infer_ctrl #(
  parameter int MEM_ADDR_YDX  = 7,
  parameter int MEM_ADDR_WGHT = 3,
  parameter int INFER_NUM     = 20,
  parameter int ATTR          = 5,
  parameter int CNT_W         = 5
`ifdef PERCEP_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT     = 64
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     infer_ena_i,
  input  logic                     yd_in_i,
  input  logic                     ya_valid_i,
  input  logic                     ya_i,
  output logic                     ydx_we_o,
  output logic                     wght_we_o,
  output logic [MEM_ADDR_YDX-1:0]  ydx_addr_o,
  output logic [MEM_ADDR_WGHT-1:0] wght_addr_o,
  output logic                     mac_valid_o,
  output logic                     mac_first_o,
  output logic                     mac_last_o,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         correct_cnt_o,
  output logic                     infer_done_o,
  output logic                     infer_fail_o
`ifdef PERCEP_CTRL_TIMEOUT_EN
  , output logic                   timeout_err_o
`endif
);

  localparam int S_W       = $clog2(INFER_NUM);
  localparam int LOAD_LAST = INFER_NUM * ATTR - 1;
`ifdef PERCEP_CTRL_TIMEOUT_EN
  localparam int WD_W      = $clog2(TIMEOUT);
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD_YDX,
    LOAD_WGHT,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [MEM_ADDR_YDX-1:0]  ydxAddr_q, ydxAddr_d;
  logic [MEM_ADDR_WGHT-1:0] wghtAddr_q, wghtAddr_d;
  logic                     ydxWe_q, ydxWe_d;
  logic                     wghtWe_q, wghtWe_d;
  logic                     macValid_q, macValid_d;
  logic                     macFirst_q, macFirst_d;
  logic                     macLast_q, macLast_d;
  logic                     busy_q, busy_d;
  logic [CNT_W-1:0]         correctCnt_q, correctCnt_d;
  logic                     inferDone_q, inferDone_d;
  logic                     inferFail_q, inferFail_d;
  logic [S_W-1:0]           sample_q, sample_d;
  logic [2:0]               attr_q, attr_d;
  logic                     ydReg_q, ydReg_d;
  logic                     waitArmed_q, waitArmed_d;
`ifdef PERCEP_CTRL_TIMEOUT_EN
  logic [WD_W-1:0]          waitCnt_q, waitCnt_d;
  logic                     timeoutErr_q, timeoutErr_d;
`endif

  logic                     accept;
  logic                     expired;
  logic [CNT_W-1:0]         cntNext;

  always_comb begin
    state_d      = state_q;
    ydxAddr_d    = ydxAddr_q;
    wghtAddr_d   = wghtAddr_q;
    ydxWe_d      = 1'b0;
    wghtWe_d     = 1'b0;
    macValid_d   = 1'b0;
    macFirst_d   = 1'b0;
    macLast_d    = 1'b0;
    correctCnt_d = correctCnt_q;
    inferDone_d  = inferDone_q;
    inferFail_d  = inferFail_q;
    sample_d     = sample_q;
    attr_d       = attr_q;
    waitArmed_d  = waitArmed_q;
    accept       = 1'b0;
    expired      = 1'b0;
    cntNext      = correctCnt_q;
`ifdef PERCEP_CTRL_TIMEOUT_EN
    waitCnt_d    = waitCnt_q;
    timeoutErr_d = timeoutErr_q;
`endif
    // Read data for the first operand of a sample carries that sample's yd bit.
    ydReg_d = (macValid_q && macFirst_q) ? yd_in_i : ydReg_q;

    unique case (state_q)
      IDLE: begin
        if (infer_ena_i) begin
          state_d      = LOAD_YDX;
          ydxWe_d      = 1'b1;
          ydxAddr_d    = '0;
          wghtAddr_d   = '0;
          correctCnt_d = '0;
          sample_d     = '0;
          attr_d       = '0;
`ifdef PERCEP_CTRL_TIMEOUT_EN
          timeoutErr_d = 1'b0;
`endif
        end
      end

      LOAD_YDX: begin
        if (!infer_ena_i) begin
          state_d   = IDLE;
          ydxAddr_d = '0;
        end else if (ydxAddr_q == MEM_ADDR_YDX'(LOAD_LAST)) begin
          state_d    = LOAD_WGHT;
          ydxAddr_d  = '0;
          wghtWe_d   = 1'b1;
          wghtAddr_d = '0;
        end else begin
          ydxWe_d   = 1'b1;
          ydxAddr_d = ydxAddr_q + MEM_ADDR_YDX'(1);
        end
      end

      LOAD_WGHT: begin
        if (!infer_ena_i) begin
          state_d    = IDLE;
          wghtAddr_d = '0;
        end else if (wghtAddr_q == MEM_ADDR_WGHT'(ATTR - 1)) begin
          state_d    = ISSUE;
          wghtAddr_d = '0;
          ydxAddr_d  = '0;
          sample_d   = '0;
          attr_d     = '0;
        end else begin
          wghtWe_d   = 1'b1;
          wghtAddr_d = wghtAddr_q + MEM_ADDR_WGHT'(1);
        end
      end

      // Flags describe the address issued this cycle; they reach the datapath one cycle later with the read data.
      ISSUE: begin
        if (!infer_ena_i) begin
          state_d   = IDLE;
          ydxAddr_d = '0;
        end else begin
          macValid_d = 1'b1;
          macFirst_d = (attr_q == 3'd0);
          macLast_d  = (attr_q == 3'(ATTR - 1));
          if (attr_q == 3'(ATTR - 1)) begin
            state_d     = WAIT;
            attr_d      = '0;
            waitArmed_d = 1'b0;
`ifdef PERCEP_CTRL_TIMEOUT_EN
            waitCnt_d   = '0;
`endif
          end else begin
            attr_d    = attr_q + 3'd1;
            ydxAddr_d = ydxAddr_q + MEM_ADDR_YDX'(1);
          end
        end
      end

      // The first WAIT cycle still carries the last operand, so a strobe there cannot belong to this sample.
      WAIT: begin
        if (!infer_ena_i) begin
          state_d   = IDLE;
          ydxAddr_d = '0;
        end else begin
          waitArmed_d = 1'b1;
          accept      = waitArmed_q && ya_valid_i;
`ifdef PERCEP_CTRL_TIMEOUT_EN
          waitCnt_d   = waitCnt_q + WD_W'(1);
          expired     = !accept && (waitCnt_q == WD_W'(TIMEOUT - 1));
          if (expired) begin
            timeoutErr_d = 1'b1;
          end
`endif
          if (accept && (ya_i == ydReg_q)) begin
            cntNext = correctCnt_q + CNT_W'(1);
          end
          correctCnt_d = cntNext;
          if (accept || expired) begin
            if (sample_q == S_W'(INFER_NUM - 1)) begin
              state_d     = DONE;
              inferDone_d = 1'b1;
              inferFail_d = (cntNext == '0);
            end else begin
              state_d   = ISSUE;
              sample_d  = sample_q + S_W'(1);
              ydxAddr_d = ydxAddr_q + MEM_ADDR_YDX'(1);
            end
          end
        end
      end

      DONE: begin
        if (!infer_ena_i) begin
          state_d     = IDLE;
          inferDone_d = 1'b0;
          inferFail_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ydxAddr_q    <= '0;
      wghtAddr_q   <= '0;
      ydxWe_q      <= 1'b0;
      wghtWe_q     <= 1'b0;
      macValid_q   <= 1'b0;
      macFirst_q   <= 1'b0;
      macLast_q    <= 1'b0;
      busy_q       <= 1'b0;
      correctCnt_q <= '0;
      inferDone_q  <= 1'b0;
      inferFail_q  <= 1'b0;
      sample_q     <= '0;
      attr_q       <= '0;
      ydReg_q      <= 1'b0;
      waitArmed_q  <= 1'b0;
`ifdef PERCEP_CTRL_TIMEOUT_EN
      waitCnt_q    <= '0;
      timeoutErr_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ydxAddr_q    <= ydxAddr_d;
      wghtAddr_q   <= wghtAddr_d;
      ydxWe_q      <= ydxWe_d;
      wghtWe_q     <= wghtWe_d;
      macValid_q   <= macValid_d;
      macFirst_q   <= macFirst_d;
      macLast_q    <= macLast_d;
      busy_q       <= busy_d;
      correctCnt_q <= correctCnt_d;
      inferDone_q  <= inferDone_d;
      inferFail_q  <= inferFail_d;
      sample_q     <= sample_d;
      attr_q       <= attr_d;
      ydReg_q      <= ydReg_d;
      waitArmed_q  <= waitArmed_d;
`ifdef PERCEP_CTRL_TIMEOUT_EN
      waitCnt_q    <= waitCnt_d;
      timeoutErr_q <= timeoutErr_d;
`endif
    end
  end

  assign ydx_we_o      = ydxWe_q;
  assign wght_we_o     = wghtWe_q;
  assign ydx_addr_o    = ydxAddr_q;
  assign wght_addr_o   = wghtAddr_q;
  assign mac_valid_o   = macValid_q;
  assign mac_first_o   = macFirst_q;
  assign mac_last_o    = macLast_q;
  assign busy_o        = busy_q;
  assign correct_cnt_o = correctCnt_q;
  assign infer_done_o  = inferDone_q;
  assign infer_fail_o  = inferFail_q;
`ifdef PERCEP_CTRL_TIMEOUT_EN
  assign timeout_err_o = timeoutErr_q;
`endif

endmodule

// File: tb/tb_percep_infer_ctrl.sv
// Bench for percep_infer_ctrl: ydx memory and MAC datapath models with a per-sample correct_cnt scoreboard.
module tb_percep_infer_ctrl;

  localparam int INFER_NUM = 20;
  localparam int ATTR      = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       infer_ena;
  logic       yd_in;
  logic       ya_valid;
  logic       ya;
  logic       ydx_we;
  logic       wght_we;
  logic [6:0] ydx_addr;
  logic [2:0] wght_addr;
  logic       mac_valid;
  logic       mac_first;
  logic       mac_last;
  logic       busy;
  logic [4:0] correct_cnt;
  logic       infer_done;
  logic       infer_fail;
`ifdef PERCEP_CTRL_TIMEOUT_EN
  logic       timeout_err;
`endif

  percep_infer_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .infer_ena_i   (infer_ena),
    .yd_in_i       (yd_in),
    .ya_valid_i    (ya_valid),
    .ya_i          (ya),
    .ydx_we_o      (ydx_we),
    .wght_we_o     (wght_we),
    .ydx_addr_o    (ydx_addr),
    .wght_addr_o   (wght_addr),
    .mac_valid_o   (mac_valid),
    .mac_first_o   (mac_first),
    .mac_last_o    (mac_last),
    .busy_o        (busy),
    .correct_cnt_o (correct_cnt),
    .infer_done_o  (infer_done),
    .infer_fail_o  (infer_fail)
`ifdef PERCEP_CTRL_TIMEOUT_EN
    , .timeout_err_o (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ydx memory: one-cycle read latency, only the yd bit matters to the controller.
  logic memYd [0:127];
  logic ydInReg = 1'b0;
  always @(posedge clk) ydInReg <= memYd[ydx_addr];
  assign yd_in = ydInReg;

  logic modelYaValid = 1'b0;
  logic modelYa      = 1'b0;
  logic spurYa       = 1'b0;
  bit   wrongMode    = 1'b0;
  bit   spurEn       = 1'b0;
  bit   withholdMode = 1'b0;
  int   respCnt      = 0;
  int   respSample   = 0;
  int   sIdx         = 0;
  int   kIdx         = 0;
  int   firstCnt     = 0;
  int   modelCnt     = 0;
  bit   checkPending = 1'b0;
  int   expQ[$];

  assign ya_valid = modelYaValid | spurYa;
  assign ya       = modelYaValid ? modelYa : 1'b1;

  // Datapath model and scoreboard: answers each sample a few cycles after mac_last and checks the count it caused.
  always @(negedge clk) begin
    if (rst) begin
      respCnt = 0; modelYaValid = 1'b0; spurYa = 1'b0; checkPending = 1'b0;
      kIdx = 0; sIdx = 0; firstCnt = 0; modelCnt = 0; expQ.delete();
    end else begin
      if (checkPending) begin
        checkOutput("cnt_after_ya", correct_cnt, expQ.pop_front());
        checkPending = 1'b0;
      end
      modelYaValid = 1'b0;
      spurYa       = 1'b0;
      if (ydx_we && ydx_addr == 7'd0) begin
        kIdx = 0; sIdx = 0; firstCnt = 0; modelCnt = 0; respCnt = 0; expQ.delete();
      end
      if (mac_valid) begin
        checkOutput("mac_first", mac_first, kIdx == 0);
        checkOutput("mac_last", mac_last, kIdx == ATTR - 1);
        if (mac_first) firstCnt++;
        kIdx = (kIdx == ATTR - 1) ? 0 : kIdx + 1;
      end
      if (mac_valid && mac_last) begin
        if (!(withholdMode && sIdx == 5)) begin
          respCnt    = 4;
          respSample = sIdx;
        end
        sIdx++;
      end
      if (respCnt > 0) begin
        respCnt--;
        if (respCnt == 0) begin
          modelYa      = wrongMode ? ~memYd[respSample*ATTR] : memYd[respSample*ATTR];
          modelYaValid = 1'b1;
          if (modelYa == memYd[respSample*ATTR]) modelCnt++;
          expQ.push_back(modelCnt);
          checkPending = 1'b1;
        end
      end
      if (spurEn && mac_valid && (mac_first || mac_last)) spurYa = 1'b1;
      if (spurEn && ydx_we && (ydx_addr == 7'd10 || ydx_addr == 7'd99)) spurYa = 1'b1;
      if (spurEn && wght_we && wght_addr == 3'd2) spurYa = 1'b1;
    end
  end

  task automatic applyStimulus(input bit wrong, input bit spur, input bit withhold);
    for (int i = 0; i < 128; i++) memYd[i] = 1'($urandom_range(0, 1));
    wrongMode    = wrong;
    spurEn       = spur;
    withholdMode = withhold;
    @(negedge clk);
    infer_ena = 1'b1;
  endtask

  task automatic checkLoad();
    for (int c = 0; c < INFER_NUM*ATTR + ATTR; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checkOutput("start_cnt_clear", correct_cnt, 0);
        checkOutput("start_busy", busy, 1);
`ifdef PERCEP_CTRL_TIMEOUT_EN
        checkOutput("start_tmo_clear", timeout_err, 0);
`endif
      end
      if (c < INFER_NUM*ATTR) begin
        checkOutput("ld_ydx_we", ydx_we, 1);
        checkOutput("ld_ydx_wght_we", wght_we, 0);
        checkOutput("ld_ydx_addr", ydx_addr, c);
      end else begin
        checkOutput("ld_w_ydx_we", ydx_we, 0);
        checkOutput("ld_w_we", wght_we, 1);
        checkOutput("ld_w_addr", wght_addr, c - INFER_NUM*ATTR);
      end
    end
  endtask

  task automatic waitDone(input int bound);
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (infer_done) break;
    end
    checkOutput("done_seen", infer_done, 1);
  endtask

  task automatic waitFirst(input int n);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (firstCnt == n) break;
    end
    checkOutput("sample_reached", firstCnt, n);
  endtask

  task automatic finishRun(input int expCnt, input bit expFail);
    @(negedge clk);
    checkOutput("final_cnt", correct_cnt, expCnt);
    checkOutput("final_done", infer_done, 1);
    checkOutput("final_fail", infer_fail, expFail);
    checkOutput("final_busy", busy, 0);
    checkOutput("sb_empty", expQ.size(), 0);
    infer_ena = 1'b0;
    @(negedge clk);
    checkOutput("idle_done", infer_done, 0);
    checkOutput("idle_fail", infer_fail, 0);
    checkOutput("idle_cnt_held", correct_cnt, expCnt);
  endtask

  initial begin
    rst       = 1'b1;
    infer_ena = 1'b0;
    for (int i = 0; i < 128; i++) memYd[i] = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ydx_we", ydx_we, 0);
    checkOutput("rst_wght_we", wght_we, 0);
    checkOutput("rst_addr", ydx_addr, 0);
    checkOutput("rst_mac_valid", mac_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cnt", correct_cnt, 0);
    checkOutput("rst_done", infer_done, 0);
    checkOutput("rst_fail", infer_fail, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_busy", busy, 0);

    $display("[TB] all-correct run");
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkLoad();
    waitDone(1000);
    finishRun(INFER_NUM, 1'b0);

    $display("[TB] all-wrong run");
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkLoad();
    waitDone(1000);
    finishRun(0, 1'b1);

    $display("[TB] spurious strobes and abort at sample 12");
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkLoad();
    waitFirst(13);
    infer_ena = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_mac_valid", mac_valid, 0);
    checkOutput("abort_ydx_we", ydx_we, 0);
    checkOutput("abort_done", infer_done, 0);
    checkOutput("abort_cnt", correct_cnt, 12);
    repeat (5) @(negedge clk);
    checkOutput("abort_done_stays", infer_done, 0);

    $display("[TB] restart after abort");
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkLoad();
    waitDone(1000);
    finishRun(INFER_NUM, 1'b0);

    $display("[TB] reset during sample 7");
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkLoad();
    waitFirst(8);
    rst = 1'b1;
    #1;
    checkOutput("mrst_mac_valid", mac_valid, 0);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_addr", ydx_addr, 0);
    checkOutput("mrst_cnt", correct_cnt, 0);
    checkOutput("mrst_done", infer_done, 0);
    infer_ena = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mrst_idle_busy", busy, 0);
    checkOutput("mrst_idle_cnt", correct_cnt, 0);
    checkOutput("mrst_idle_ydx_we", ydx_we, 0);

`ifdef PERCEP_CTRL_TIMEOUT_EN
    $display("[TB] withheld result on sample 5");
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkLoad();
    waitDone(3000);
    checkOutput("tmo_err", timeout_err, 1);
    finishRun(INFER_NUM - 1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
